pwm_gen: RTL

- Downstream consumer of the free-running `counter` value.
- Compares the count against a programmable duty value and produces a registered PWM output.
- Duty updates are double-buffered so they apply only at a period boundary (counter wrap). An optional soft ramp steps duty by 1 per period.
- Sits between `counter` and the top-level output pins.

---
 rtl/pwm_gen_pkg.sv | 15 +
 rtl/pwm_gen_wrap_detect.sv | 24 ++
 rtl/pwm_gen.sv | 117 +++++++++++
 3 files changed

// File: rtl/pwm_gen_pkg.sv
// rtl/pwm_gen_pkg.sv - shared state encoding and duty helpers for pwm_gen
package pwm_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RAMP = 2'd2
    } state_e;

    // Full-scale duty for a counter of width bw: output held high the whole period.
    function automatic int unsigned duty_max(input int unsigned bw);
        return 32'd1 << bw;
    endfunction

endpackage

// File: rtl/pwm_gen_wrap_detect.sv
// rtl/pwm_gen_wrap_detect.sv - detects a wrap of a free-running counter value
module wrap_detect #(
    parameter int BW = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [BW-1:0] cnt_val_i,
    output logic          boundary_o
);

    logic [BW-1:0] prev_q;

    // Previous count starts at all ones so the first zero seen after reset is a wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= '1;
        end else begin
            prev_q <= cnt_val_i;
        end
    end

    assign boundary_o = (cnt_val_i < prev_q);

endmodule

// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - double-buffered PWM generator with optional per-period duty ramp
module pwm_gen
    import pwm_gen_pkg::*;
#(
    parameter int BW = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [BW-1:0] cnt_val_i,
    input  logic          en_i,
    input  logic [BW:0]   duty_i,
    input  logic          duty_wr_i,
    input  logic          ramp_i,
    output logic          pwm_o,
    output logic          period_o,
    output logic          busy_o
);

    localparam logic [BW:0] DMAX = (BW+1)'(duty_max(BW));

    logic        boundary;
    state_e      state_q, state_d;
    logic [BW:0] active_q, active_d;
    logic [BW:0] pend_q, pend_d;
    logic        pvalid_q, pvalid_d;
    logic        ramp_q, ramp_d;
    logic        pwm_q, pwm_d;
    logic        period_q, period_d;
    logic        busy_q, busy_d;
    logic [BW:0] duty_sat;
    logic [BW:0] step_val;

    wrap_detect #(.BW(BW)) u_wrap (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cnt_val_i  (cnt_val_i),
        .boundary_o (boundary)
    );

    // Next-state: apply or step the pending duty at a wrap, then capture any new write.
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        pend_d   = pend_q;
        pvalid_d = pvalid_q;
        ramp_d   = ramp_q;

        duty_sat = (duty_i > DMAX) ? DMAX : duty_i;

        if (active_q < pend_q) begin
            step_val = active_q + (BW+1)'(1);
        end else if (active_q > pend_q) begin
            step_val = active_q - (BW+1)'(1);
        end else begin
            step_val = active_q;
        end

        if (!en_i) begin
            state_d = ST_IDLE;
        end else if (boundary) begin
            state_d = ST_RUN;
            if (pvalid_q) begin
                // An interrupted ramp resumes through the latched flag after re-enable.
                if (ramp_q || (state_q == ST_RAMP)) begin
                    active_d = step_val;
                    if (step_val == pend_q) begin
                        pvalid_d = 1'b0;
                    end else begin
                        state_d = ST_RAMP;
                    end
                end else begin
                    active_d = pend_q;
                    pvalid_d = 1'b0;
                end
            end
        end

        // A write on the wrap cycle lands after the apply, so it waits for the next wrap.
        if (duty_wr_i) begin
            pend_d   = duty_sat;
            pvalid_d = 1'b1;
            ramp_d   = ramp_i;
        end

        pwm_d    = (state_d != ST_IDLE) && ({1'b0, cnt_val_i} < active_d);
        period_d = boundary && (state_d != ST_IDLE);
        busy_d   = pvalid_d || (state_d == ST_RAMP);
    end

    // State and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            active_q <= '0;
            pend_q   <= '0;
            pvalid_q <= 1'b0;
            ramp_q   <= 1'b0;
            pwm_q    <= 1'b0;
            period_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            pvalid_q <= pvalid_d;
            ramp_q   <= ramp_d;
            pwm_q    <= pwm_d;
            period_q <= period_d;
            busy_q   <= busy_d;
        end
    end

    assign pwm_o    = pwm_q;
    assign period_o = period_q;
    assign busy_o   = busy_q;

endmodule
